sisc_ctrl_mc: RTL and testbench

Parametrised multi-cycle control FSM for the SISC datapath. It is the successor to the fixed 4-bit controller. It adds:
- configurable opcode and condition-code widths;
- load, store and swap sequencing;
- a request/acknowledge stall handshake to data memory;
- a latched HALT state in place of a simulator stop.

It sits between the IR, the status register and the datapath select/enable lines.

---
 rtl/sisc_ctrl_mc.sv | 188 ++++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc: multi-cycle control FSM for the SISC datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB(/WB2) per instruction, stalls in MEM
// on data-memory request/acknowledge, and parks in a latched HALT state.
// Ports:
//   clk, rst_f      - clock, synchronous active-low reset
//   opcode, mm      - IR opcode and mode/condition-mask fields
//   stat            - status register flags
//   dm_ack          - data memory transfer complete
//   rf_we, wb_sel, swp_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel,
//   rb_sel, ir_load, dm_req, dm_we, halted - datapath controls (combinational)
module sisc_ctrl_mc #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned CCW     = 4,
  parameter int unsigned IMM_MM  = 8,
  parameter int unsigned OP_NOOP = 0,
  parameter int unsigned OP_LOD  = 1,
  parameter int unsigned OP_STR  = 2,
  parameter int unsigned OP_SWP  = 3,
  parameter int unsigned OP_BRA  = 4,
  parameter int unsigned OP_BRR  = 5,
  parameter int unsigned OP_BNE  = 6,
  parameter int unsigned OP_BNR  = 7,
  parameter int unsigned OP_ALU  = 8,
  parameter int unsigned OP_HLT  = 15
) (
  input  logic           clk,
  input  logic           rst_f,
  input  logic [OPW-1:0] opcode,
  input  logic [CCW-1:0] mm,
  input  logic [CCW-1:0] stat,
  input  logic           dm_ack,
  output logic           rf_we,
  output logic           wb_sel,
  output logic           swp_sel,
  output logic [1:0]     alu_op,
  output logic           br_sel,
  output logic           pc_rst,
  output logic           pc_write,
  output logic           pc_sel,
  output logic           rb_sel,
  output logic           ir_load,
  output logic           dm_req,
  output logic           dm_we,
  output logic           halted
);

  typedef enum logic [2:0] {
    S_START1  = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_WB2     = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_LOD, C_STR, C_SWP, C_BRA, C_BRR, C_BNE, C_BNR, C_ALU, C_HLT
  } op_class_t;

  state_t    state;
  state_t    state_nx;
  op_class_t cls;
  logic      cc_hit;
  logic      taken;
  logic      alu_imm;
  logic      mem_op;
  logic      is_str;

  // Opcode classification; unencoded opcodes fall through as NOOP.
  always_comb begin
    cls = C_NOP;
    case (opcode)
      OPW'(OP_NOOP): cls = C_NOP;
      OPW'(OP_LOD):  cls = C_LOD;
      OPW'(OP_STR):  cls = C_STR;
      OPW'(OP_SWP):  cls = C_SWP;
      OPW'(OP_BRA):  cls = C_BRA;
      OPW'(OP_BRR):  cls = C_BRR;
      OPW'(OP_BNE):  cls = C_BNE;
      OPW'(OP_BNR):  cls = C_BNR;
      OPW'(OP_ALU):  cls = C_ALU;
      OPW'(OP_HLT):  cls = C_HLT;
      default:       cls = C_NOP;
    endcase
  end

  // Branch condition: BRA/BRR take on any masked flag, BNE/BNR on none.
  always_comb begin
    cc_hit = |(mm & stat);
    taken  = 1'b0;
    case (cls)
      C_BRA, C_BRR: taken = cc_hit;
      C_BNE, C_BNR: taken = ~cc_hit;
      default:      taken = 1'b0;
    endcase
  end

  assign alu_imm = (cls == C_ALU) && (mm == CCW'(IMM_MM));
  assign mem_op  = (cls == C_LOD) || (cls == C_STR);
  assign is_str  = (cls == C_STR);

  // State register; reset wins over every state, including MEM and HALT.
  always_ff @(posedge clk) begin
    if (!rst_f) state <= S_START1;
    else        state <= state_nx;
  end

  // Next-state and control outputs.
  always_comb begin
    state_nx = state;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    swp_sel  = 1'b0;
    alu_op   = 2'b10;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    rb_sel   = 1'b0;
    ir_load  = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    case (state)
      S_START1: begin
        pc_rst   = 1'b1;
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = (cls == C_BRA) || (cls == C_BNE);
        end
        state_nx = (cls == C_HLT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_op   = alu_imm ? 2'b01 : 2'b00;
        rb_sel   = is_str;
        state_nx = S_MEM;
      end
      S_MEM: begin
        alu_op = alu_imm ? 2'b11 : 2'b10;
        if (mem_op) begin
          dm_req   = 1'b1;
          dm_we    = is_str;
          rb_sel   = is_str;
          state_nx = dm_ack ? S_WB : S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        state_nx = S_FETCH;
        case (cls)
          C_ALU: rf_we = 1'b1;
          C_LOD: begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
          end
          C_SWP: begin
            rf_we    = 1'b1;
            state_nx = S_WB2;
          end
          default: ;
        endcase
      end
      S_WB2: begin
        rf_we    = 1'b1;
        swp_sel  = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT: begin
        halted   = 1'b1;
        state_nx = S_HALT;
      end
      default: state_nx = S_START1;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// tb_sisc_ctrl_mc: self-checking bench for sisc_ctrl_mc. An instruction-level
// model expands each instruction into its expected per-cycle control trace.
module tb_sisc_ctrl_mc;

  localparam int unsigned OPW = 4;
  localparam int unsigned CCW = 4;

  logic           clk = 1'b0;
  logic           rst_f;
  logic [OPW-1:0] opcode;
  logic [CCW-1:0] mm;
  logic [CCW-1:0] stat;
  logic           dm_ack;
  logic           rf_we, wb_sel, swp_sel, br_sel, pc_rst, pc_write, pc_sel;
  logic           rb_sel, ir_load, dm_req, dm_we, halted;
  logic [1:0]     alu_op;

  typedef struct packed {
    logic       rf_we;
    logic       wb_sel;
    logic       swp_sel;
    logic [1:0] alu_op;
    logic       br_sel;
    logic       pc_rst;
    logic       pc_write;
    logic       pc_sel;
    logic       rb_sel;
    logic       ir_load;
    logic       dm_req;
    logic       dm_we;
    logic       halted;
  } ov_t;

  ov_t cur;
  ov_t exp_q[$];
  ov_t obs_q[$];
  int  tests = 0;
  int  fails = 0;

  sisc_ctrl_mc dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .dm_ack(dm_ack), .rf_we(rf_we), .wb_sel(wb_sel), .swp_sel(swp_sel),
    .alu_op(alu_op), .br_sel(br_sel), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .rb_sel(rb_sel), .ir_load(ir_load), .dm_req(dm_req),
    .dm_we(dm_we), .halted(halted)
  );

  always #5 clk = ~clk;

  assign cur = '{rf_we, wb_sel, swp_sel, alu_op, br_sel, pc_rst, pc_write,
                 pc_sel, rb_sel, ir_load, dm_req, dm_we, halted};

  function automatic ov_t dflt();
    ov_t v = '0;
    v.alu_op = 2'b10;
    return v;
  endfunction

  function automatic ov_t v_start();
    ov_t v = dflt();
    v.pc_rst = 1'b1;
    return v;
  endfunction

  function automatic ov_t v_fetch();
    ov_t v = dflt();
    v.ir_load  = 1'b1;
    v.pc_write = 1'b1;
    return v;
  endfunction

  function automatic ov_t v_halt();
    ov_t v = dflt();
    v.halted = 1'b1;
    return v;
  endfunction

  // Reference model: expected control trace from FETCH up to the last cycle
  // before the next FETCH (HLT stops after DECODE).
  function automatic void build_trace(int op, logic [3:0] m, logic [3:0] s, int stall);
    ov_t v;
    bit  hit   = |(m & s);
    bit  imm   = (op == 8) && (m == 4'd8);
    bit  memop = (op == 1) || (op == 2);
    bit  tk    = ((op == 4 || op == 5) && hit) || ((op == 6 || op == 7) && !hit);
    exp_q.delete();
    exp_q.push_back(v_fetch());
    v = dflt();
    if (tk) begin
      v.pc_write = 1'b1;
      v.pc_sel   = 1'b1;
      v.br_sel   = (op == 4 || op == 6);
    end
    exp_q.push_back(v);
    if (op == 15) return;
    v = dflt();
    v.alu_op = imm ? 2'b01 : 2'b00;
    v.rb_sel = (op == 2);
    exp_q.push_back(v);
    for (int i = 0; i < (memop ? stall + 1 : 1); i++) begin
      v = dflt();
      v.alu_op = imm ? 2'b11 : 2'b10;
      if (memop) begin
        v.dm_req = 1'b1;
        v.dm_we  = (op == 2);
        v.rb_sel = (op == 2);
      end
      exp_q.push_back(v);
    end
    v = dflt();
    v.rf_we  = (op == 8) || (op == 1) || (op == 3);
    v.wb_sel = (op == 1);
    exp_q.push_back(v);
    if (op == 3) begin
      v = dflt();
      v.rf_we   = 1'b1;
      v.swp_sel = 1'b1;
      exp_q.push_back(v);
    end
  endfunction

  // Drives one instruction from FETCH for exp_q.size() cycles and records
  // outputs. dm_ack is random except inside the memory stall window.
  task automatic drive_instr(int op, logic [3:0] m, logic [3:0] s, int stall);
    bit memop = (op == 1) || (op == 2);
    opcode = OPW'(op);
    mm     = m;
    stat   = s;
    obs_q.delete();
    for (int k = 0; k < exp_q.size(); k++) begin
      if (memop && k >= 3 && k <= 3 + stall) dm_ack = (k == 3 + stall);
      else                                   dm_ack = 1'($urandom_range(1));
      #1;
      obs_q.push_back(cur);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_f = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++;
      if (cur !== v_start()) begin
        fails++;
        $display("FAIL reset_hold cyc %0d got %h exp %h", i, cur, v_start());
      end
    end
    rst_f = 1'b1;
    #1;
    tests++;
    if (cur !== v_start()) begin
      fails++;
      $display("FAIL reset_release got %h exp %h", cur, v_start());
    end
    @(posedge clk); #1;
    tests++;
    if (cur !== v_fetch()) begin
      fails++;
      $display("FAIL reset_to_fetch got %h exp %h", cur, v_fetch());
    end
  endtask

  task automatic test_alu();
    build_trace(8, 4'd8, 4'd0, 0);
    drive_instr(8, 4'd8, 4'd0, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL alu_imm cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_branches();
    int          ops[3] = '{4, 7, 7};
    logic [3:0]  sts[3] = '{4'b0010, 4'b0010, 4'b0000};
    for (int t = 0; t < 3; t++) begin
      build_trace(ops[t], 4'b0010, sts[t], 0);
      drive_instr(ops[t], 4'b0010, sts[t], 0);
      for (int k = 0; k < exp_q.size(); k++) begin
        tests++;
        if (obs_q[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL branch%0d cyc %0d got %h exp %h", t, k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_lod_stall();
    build_trace(1, 4'd3, 4'd0, 3);
    drive_instr(1, 4'd3, 4'd0, 3);
    for (int k = 0; k < exp_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL lod_stall cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    // Ninth cycle after FETCH must be the next FETCH.
    tests++;
    if (cur !== v_fetch()) begin
      fails++;
      $display("FAIL lod_latency got %h exp %h", cur, v_fetch());
    end
  endtask

  task automatic test_str();
    build_trace(2, 4'd1, 4'd5, 0);
    drive_instr(2, 4'd1, 4'd5, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL str cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_swp();
    build_trace(3, 4'd8, 4'd0, 0);
    drive_instr(3, 4'd8, 4'd0, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL swp cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    tests++;
    if (cur !== v_fetch()) begin
      fails++;
      $display("FAIL swp_return got %h exp %h", cur, v_fetch());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int         op = $urandom_range(14);
      logic [3:0] m  = ($urandom_range(3) == 0) ? 4'd8 : 4'($urandom);
      logic [3:0] s  = 4'($urandom);
      int         st = $urandom_range(3);
      build_trace(op, m, s, st);
      drive_instr(op, m, s, st);
      for (int k = 0; k < exp_q.size(); k++) begin
        tests++;
        if (obs_q[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL random n%0d op%0d cyc %0d got %h exp %h", n, op, k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_halt();
    build_trace(15, 4'd0, 4'd0, 0);
    drive_instr(15, 4'd0, 4'd0, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL hlt_decode cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      opcode = OPW'($urandom);
      dm_ack = 1'($urandom_range(1));
      #1;
      tests++;
      if (cur !== v_halt()) begin
        fails++;
        $display("FAIL halt_hold cyc %0d got %h exp %h", i, cur, v_halt());
      end
      @(posedge clk); #1;
    end
    rst_f = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (cur !== v_start()) begin
      fails++;
      $display("FAIL halt_reset got %h exp %h", cur, v_start());
    end
    rst_f = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (cur !== v_fetch()) begin
      fails++;
      $display("FAIL halt_restart got %h exp %h", cur, v_fetch());
    end
  endtask

  task automatic test_reset_mid_stall();
    opcode = OPW'(1);
    mm     = 4'd0;
    stat   = 4'd0;
    dm_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (dm_req !== 1'b1) begin
      fails++;
      $display("FAIL stall_dm_req got %b exp 1", dm_req);
    end
    rst_f = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (cur !== v_start()) begin
      fails++;
      $display("FAIL stall_reset got %h exp %h", cur, v_start());
    end
    rst_f = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (cur !== v_fetch()) begin
      fails++;
      $display("FAIL stall_restart got %h exp %h", cur, v_fetch());
    end
  endtask

  initial begin
    rst_f  = 1'b0;
    opcode = '0;
    mm     = '0;
    stat   = '0;
    dm_ack = 1'b0;
    test_reset();
    test_alu();
    test_branches();
    test_lod_stall();
    test_str();
    test_swp();
    test_random();
    test_halt();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
